// File: rtl/fpu_sp_pkg.sv
// Shared definitions for the single-precision FPU issue sequencer:
// opcode encodings, sequencer state encoding and IEEE-754 special values.
package fpu_sp_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    localparam logic [31:0] SP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] SP_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] SP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] SP_NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] SP_QNAN     = 32'h7FC0_0000;

    // NaN: exponent all ones with a non-zero mantissa (infinity is not NaN).
    function automatic logic is_nan_sp(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fpu_sp_sequencer_if.sv
// Request and response channels of the FPU sequencer. The master side
// produces requests and consumes responses; the sequencer is the slave.
interface fpu_sp_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;
    logic             out_unf;
    logic             out_nan;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_nan, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_nan, out_tag
    );
endinterface

// File: rtl/fpu_sp_op_fifo.sv
// Synchronous request FIFO. Callers only push when not full and only pop
// when not empty; there is no write-through path, so a pushed entry is
// visible at the head no earlier than the following edge.
module fpu_sp_op_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/fpu_sp_sequencer.sv
// Issue stage in front of the single-precision FPU. Requests are queued,
// issued one at a time with operands held for LAT edges, and the captured
// result is returned in request order.
//
// state | meaning
// IDLE  | nothing in flight; issue the FIFO head when one is present
// WAIT  | operands held on fpu_*; counting up to LAT before capture
// RESP  | response presented on out_*; held until the consumer accepts
module fpu_sp_sequencer
    import fpu_sp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fpu_sp_sequencer_if.slave bus,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic [1:0]       fpu_op,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ovf,
    input  logic             fpu_unf,
    output logic             busy
);
    localparam int DW = 2*WIDTH + 2 + TAG_W;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_CNT = CW'(LAT);

    seq_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [DW-1:0]           fifo_din;
    logic [DW-1:0]           fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    capture;

    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_ovf_q;
    logic             out_unf_q;
    logic             out_nan_q;
    logic [TAG_W-1:0] out_tag_q;

    // Backpressure depends only on fullness; a pop in the same cycle does
    // not free a slot early.
    assign bus.in_ready = rst_n & ~fifo_full;
    assign fifo_push    = bus.in_valid & bus.in_ready;
    assign fifo_din     = {bus.in_tag, bus.in_op, bus.in_b, bus.in_a};

    fpu_sp_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; RESP can issue the next entry on the handshake edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_CNT) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cnt_d    = '0;
                        state_d  = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand launch on pop and result capture at the end of the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpu_a        <= SP_POS_ZERO;
            fpu_b        <= SP_POS_ZERO;
            fpu_op       <= OP_ADD;
            tag_q        <= '0;
            out_result_q <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            out_nan_q    <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            if (fifo_pop) begin
                {tag_q, fpu_op, fpu_b, fpu_a} <= fifo_dout;
            end
            if (capture) begin
                out_result_q <= fpu_result;
                out_ovf_q    <= fpu_ovf;
                out_unf_q    <= fpu_unf;
                out_nan_q    <= is_nan_sp(fpu_result);
                out_tag_q    <= tag_q;
            end
        end
    end

    assign bus.out_valid  = (state_q == RESP);
    assign bus.out_result = out_result_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_unf    = out_unf_q;
    assign bus.out_nan    = out_nan_q;
    assign bus.out_tag    = out_tag_q;

    assign busy = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_fpu_sp_sequencer.sv
// Bench for the FPU sequencer: a behavioural one-stage FPU built on real
// arithmetic, a queue-based reference of expected responses, and directed
// plus randomized request streams.
module tb_fpu_sp_sequencer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [WIDTH-1:0] fpu_a, fpu_b, fpu_result;
    logic [1:0]       fpu_op;
    logic             fpu_ovf, fpu_unf, busy;

    fpu_sp_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    fpu_sp_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LAT   (LAT),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .fpu_ovf    (fpu_ovf),
        .fpu_unf    (fpu_unf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural FPU ----------------
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = 11'(int'(s[30:23]) - 127 + 1023);
        d = {s[31], e, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        real x, y, r;
        x = sp2r(a);
        y = sp2r(b);
        case (op)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = (y == 0.0) ? 0.0 : x / y;
        endcase
        return r2sp(r);
    endfunction

    function automatic logic ovf_fn(input logic [31:0] r);
        return r[30:23] == 8'hFF;
    endfunction

    function automatic logic unf_fn(input logic [31:0] r);
        return (r[30:0] != 31'd0) && (r[30:23] < 8'd122);
    endfunction

    function automatic logic nan_rule(input logic [31:0] r);
        return (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
    endfunction

    logic [31:0] res_q = '0;
    logic        ovf_q = 1'b0, unf_q = 1'b0;
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic        force_ovf = 1'b0, force_unf = 1'b0;

    always @(posedge clk) begin
        res_q <= fpu_fn(fpu_a, fpu_b, fpu_op);
        ovf_q <= ovf_fn(fpu_fn(fpu_a, fpu_b, fpu_op));
        unf_q <= unf_fn(fpu_fn(fpu_a, fpu_b, fpu_op));
    end

    assign fpu_result = force_en ? force_val : res_q;
    assign fpu_ovf    = force_en ? force_ovf : ovf_q;
    assign fpu_unf    = force_en ? force_unf : unf_q;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference queue / monitor ----------------
    typedef struct {
        logic [31:0]      res;
        logic             ovf;
        logic             unf;
        logic             nan;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   n_resp  = 0;
    int   cyc     = 0;
    int   last_hs = -1;
    bit   chk_gap = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        exp_t h;
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 64'(bus.out_valid), 64'd0);
                end else if (bus.out_ready) begin
                    h = q.pop_front();
                    chk("resp_result", 64'(bus.out_result), 64'(h.res));
                    chk("resp_tag",    64'(bus.out_tag),    64'(h.tag));
                    chk("resp_ovf",    64'(bus.out_ovf),    64'(h.ovf));
                    chk("resp_unf",    64'(bus.out_unf),    64'(h.unf));
                    chk("resp_nan",    64'(bus.out_nan),    64'(h.nan));
                    n_resp++;
                    if (chk_gap && last_hs >= 0) chk("resp_gap", 64'(cyc - last_hs), 64'(LAT + 2));
                    last_hs = cyc;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.res = force_en ? force_val : fpu_fn(bus.in_a, bus.in_b, bus.in_op);
                e.ovf = force_en ? force_ovf : ovf_fn(e.res);
                e.unf = force_en ? force_unf : unf_fn(e.res);
                e.nan = nan_rule(e.res);
                e.tag = bus.in_tag;
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_rdy = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = r2sp(real'($urandom_range(1, 200)));
        v[31] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bit accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) begin
                accepted = 1'b1;
                step();
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        if (!accepted) chk("send_timeout", 64'(accepted), 64'd1);
    endtask

    task automatic drain(input int limit);
        bit done;
        done = (q.size() == 0);
        for (int i = 0; i < limit && !done; i++) begin
            step();
            done = (q.size() == 0);
        end
        if (!done) chk("drain_timeout", 64'(done), 64'd1);
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin
        int acc;
        int base;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = 2'b00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_busy",      64'(busy),           64'd0);
        chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
        chk("rst_fpu_a",     64'(fpu_a),          64'd0);
        chk("rst_fpu_op",    64'(fpu_op),         64'd0);
        chk("rst_out_res",   64'(bus.out_result), 64'd0);
        chk("rst_in_ready1", 64'(bus.in_ready),   64'd1);

        // Single ADD: 1.0 + 2.0 with exact response timing.
        bus.out_ready = 1'b1;
        send(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd5);
        chk("add_valid_t0", 64'(bus.out_valid), 64'd0);
        step();
        chk("add_valid_t1", 64'(bus.out_valid), 64'd0);
        chk("add_fpu_a",    64'(fpu_a),         64'h3F80_0000);
        step();
        chk("add_valid_t2", 64'(bus.out_valid), 64'd0);
        step();
        chk("add_valid_t3", 64'(bus.out_valid), 64'd1);
        chk("add_result",   64'(bus.out_result), 64'h4040_0000);
        chk("add_tag",      64'(bus.out_tag),    64'd5);
        chk("add_nan",      64'(bus.out_nan),    64'd0);
        step();
        chk("add_busy_after", 64'(busy), 64'd0);

        // Fill with the consumer stalled: one in flight plus DEPTH queued.
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = rand_operand();
            bus.in_b     = rand_operand();
            bus.in_op    = 2'b10;
            bus.in_tag   = TAG_W'(i);
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_accepted", 64'(acc), 64'(DEPTH + 1));
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid",  64'(bus.out_valid), 64'd1);
            chk("stall_tag",    64'(bus.out_tag),    64'(q[0].tag));
            chk("stall_result", 64'(bus.out_result), 64'(q[0].res));
            step();
        end

        // Drain: in-order tags with LAT+2 spacing, busy low right after.
        base    = n_resp;
        chk_gap = 1'b1;
        last_hs = -1;
        bus.out_ready = 1'b1;
        drain(100);
        chk_gap = 1'b0;
        chk("drain_count", 64'(n_resp - base), 64'(DEPTH + 1));
        chk("drain_busy",  64'(busy), 64'd0);

        // NaN and overflow flag capture.
        force_en  = 1'b1;
        force_val = 32'h7FC0_0000;
        force_ovf = 1'b0;
        force_unf = 1'b0;
        send(rand_operand(), rand_operand(), 2'b11, 4'd10);
        drain(50);
        force_val = 32'h7F80_0000;
        force_ovf = 1'b1;
        send(rand_operand(), rand_operand(), 2'b10, 4'd11);
        for (int i = 0; i < 50 && !bus.out_valid; i++) step();
        chk("inf_nan", 64'(bus.out_nan), 64'd0);
        chk("inf_ovf", 64'(bus.out_ovf), 64'd1);
        drain(50);
        force_en = 1'b0;

        // Reset during WAIT with two entries queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = rand_operand();
            bus.in_b     = rand_operand();
            bus.in_op    = 2'b11;
            bus.in_tag   = TAG_W'(7 + i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_fpu_op", 64'(fpu_op), 64'd3);
        rst_n = 1'b0;
        step();
        chk("midrst_valid",    64'(bus.out_valid), 64'd0);
        chk("midrst_busy",     64'(busy),          64'd0);
        chk("midrst_fpu_op",   64'(fpu_op),        64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready),  64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
        end

        // Pointer wrap: 3*DEPTH MUL requests with a random consumer.
        base     = n_resp;
        rand_rdy = 1'b1;
        for (int i = 0; i < 3*DEPTH; i++) begin
            send(rand_operand(), rand_operand(), 2'b10, TAG_W'(i));
            if ($urandom_range(0, 2) == 0) step();
        end
        drain(500);
        chk("wrap_count", 64'(n_resp - base), 64'(3*DEPTH));

        // Mixed opcodes with a random consumer.
        base = n_resp;
        for (int i = 0; i < 8; i++) begin
            send(rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), TAG_W'($urandom));
        end
        drain(500);
        rand_rdy = 1'b0;
        chk("mixed_count", 64'(n_resp - base), 64'd8);
        step();
        chk("final_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
